// File: rtl/iq_pair_fifo_if.sv
// Handshake/data bundle for iq_pair_fifo: push side, registered pop side, status and stats.
interface iq_pair_fifo_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 1024
);
    logic                     wr_en;
    logic [DATA_WIDTH-1:0]    real_in;
    logic [DATA_WIDTH-1:0]    imag_in;
    logic                     rd_en;
    logic [DATA_WIDTH-1:0]    real_out;
    logic [DATA_WIDTH-1:0]    imag_out;
    logic                     out_valid;
    logic                     full;
    logic                     almost_full;
    logic                     empty;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic                     underflow;
    logic [15:0]              drop_cnt;

    modport master (
        output wr_en, real_in, imag_in, rd_en,
        input  real_out, imag_out, out_valid, full, almost_full, empty, count,
        input  overflow, underflow, drop_cnt
    );

    modport slave (
        input  wr_en, real_in, imag_in, rd_en,
        output real_out, imag_out, out_valid, full, almost_full, empty, count,
        output overflow, underflow, drop_cnt
    );
endinterface

// File: rtl/iq_pair_fifo.sv
// Single-clock FIFO keeping real/imag samples as one lockstep pair, with registered read path.
// Optional error statistics (overflow/underflow/drop_cnt) enabled by defining IQ_FIFO_STATS_EN.
module iq_pair_fifo #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned AFULL_THRESH = DEPTH - 4
) (
    input logic           clk,
    input logic           reset,
    iq_pair_fifo_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [2*DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] real_q, imag_q;
    logic                  valid_q;
    logic                  at_full, at_empty;
    logic                  wr_acc, rd_acc;

    // Flags come only from the registered count, so rd_en/wr_en never reach them combinationally.
    assign at_full  = (count_q == CW'(DEPTH));
    assign at_empty = (count_q == '0);
    assign wr_acc   = bus.wr_en && !at_full;
    assign rd_acc   = bus.rd_en && !at_empty;

    always_comb begin
        count_d = count_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= {bus.real_in, bus.imag_in};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            real_q   <= '0;
            imag_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            valid_q <= rd_acc;
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd_acc) begin
                {real_q, imag_q} <= mem[rd_ptr_q];
                rd_ptr_q         <= rd_ptr_q + AW'(1);
            end
        end
    end

    assign bus.real_out    = real_q;
    assign bus.imag_out    = imag_q;
    assign bus.out_valid   = valid_q;
    assign bus.full        = at_full;
    assign bus.empty       = at_empty;
    assign bus.almost_full = (count_q >= CW'(AFULL_THRESH));
    assign bus.count       = count_q;

`ifdef IQ_FIFO_STATS_EN
    logic        overflow_q, underflow_q;
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            if (bus.wr_en && at_full) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != 16'hFFFF) begin
                    drop_cnt_q <= drop_cnt_q + 16'd1;
                end
            end
            if (bus.rd_en && at_empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
    assign bus.drop_cnt  = drop_cnt_q;
`else
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
    assign bus.drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_iq_pair_fifo.sv
// Self-checking bench for iq_pair_fifo (DEPTH=8, AFULL_THRESH=6) against a queue-based model.
module tb_iq_pair_fifo;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AFULL = 6;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    iq_pair_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    iq_pair_fifo #(
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .AFULL_THRESH(AFULL)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] q[$];
    logic [63:0] exp_out;
    logic        exp_valid;
    logic        exp_ovf, exp_unf;
    int          exp_drop;
    bit          stats_on;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        q.delete();
        exp_out   = '0;
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
        exp_unf   = 1'b0;
        exp_drop  = 0;
    endtask

    task automatic check_all(input string tag);
        logic [17:0] exp_stats;
        int          n;
        n = q.size();
        exp_stats = stats_on ? {exp_ovf, exp_unf, 16'(exp_drop)} : 18'd0;
        check({tag, ".data"}, {bus.real_out, bus.imag_out}, exp_out);
        check({tag, ".valid"}, 64'(bus.out_valid), 64'(exp_valid));
        check({tag, ".count"}, 64'(bus.count), 64'(n));
        check({tag, ".flags"}, 64'({bus.full, bus.almost_full, bus.empty}),
              64'({n == DEPTH, n >= AFULL, n == 0}));
        check({tag, ".stats"}, 64'({bus.overflow, bus.underflow, bus.drop_cnt}), 64'(exp_stats));
    endtask

    // Drive one cycle of inputs, advance the model by the FIFO rules, then check outputs.
    task automatic step(input bit we, input bit re, input logic [31:0] r, input logic [31:0] i,
                        input string tag);
        bit aw, ar;
        bus.wr_en   = we;
        bus.rd_en   = re;
        bus.real_in = r;
        bus.imag_in = i;
        aw = we && (q.size() < DEPTH);
        ar = re && (q.size() > 0);
        if (we && q.size() == DEPTH) begin
            exp_ovf = 1'b1;
            if (exp_drop < 65535) exp_drop++;
        end
        if (re && q.size() == 0) exp_unf = 1'b1;
        @(posedge clk);
        exp_valid = ar;
        if (ar) exp_out = q.pop_front();
        if (aw) q.push_back({r, i});
        #1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        check_all(tag);
    endtask

    initial begin
        int          pushed, popped, cyc;
        bit          we, re;
        logic [31:0] rr, ii;
`ifdef IQ_FIFO_STATS_EN
        stats_on = 1'b1;
`else
        stats_on = 1'b0;
`endif
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.real_in = '0;
        bus.imag_in = '0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 1: three pairs in, three out
        for (int k = 1; k <= 3; k++) step(1, 0, k, -k, "t1_push");
        for (int k = 1; k <= 3; k++) step(0, 1, 0, 0, "t1_pop");
        step(0, 0, 0, 0, "t1_idle");

        // 2: overfill, then drain
        for (int k = 1; k <= 10; k++) step(1, 0, 32'h100 + k, -(32'h100 + k), "t2_fill");
        for (int k = 0; k < 8; k++) step(0, 1, 0, 0, "t2_drain");
        step(0, 0, 0, 0, "t2_idle");

        // 3: read+write at full, then steady occupancy 4
        for (int k = 0; k < 8; k++) step(1, 0, $urandom, $urandom, "t3_fill");
        step(1, 1, 32'hDEAD, 32'hBEEF, "t3_full_rw");
        for (int k = 0; k < 3; k++) step(0, 1, 0, 0, "t3_to4");
        for (int k = 0; k < 20; k++) step(1, 1, $urandom, $urandom, "t3_steady");
        for (int k = 0; k < 4; k++) step(0, 1, 0, 0, "t3_drain");

        // 4: read+write at empty
        step(1, 1, 32'h44, -32'h44, "t4_empty_rw");
        step(0, 1, 0, 0, "t4_pop");
        step(0, 0, 0, 0, "t4_idle");

        // 5: random stream of 100 pairs
        pushed = 0;
        popped = 0;
        cyc    = 0;
        while (popped < 100 && cyc < 3000) begin
            we = (pushed < 100) && ($urandom_range(0, 99) < 55);
            re = ($urandom_range(0, 99) < 50);
            rr = $urandom;
            ii = $urandom;
            if (we && q.size() < DEPTH) pushed++;
            if (re && q.size() > 0) popped++;
            step(we, re, rr, ii, "t5_stream");
            cyc++;
        end
        check("t5_completed", 64'(popped), 64'd100);

        // 6: asynchronous reset at count 5
        for (int k = 0; k < 5; k++) step(1, 0, $urandom, $urandom, "t6_fill");
        step(1, 1, 32'h1, 32'h2, "t6_rw");
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("t6_async_rst");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        step(1, 0, 7, -7, "t6_push");
        step(0, 1, 0, 0, "t6_pop");
        check("t6_pair", {bus.real_out, bus.imag_out}, {32'd7, -32'd7});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
